// File: rtl/adder_share_pkg.sv
// Purpose : shared constants and types for the two-requester shared adder.
// Contents: default operand width, FSM state encoding, op counter ceiling.
// Used by : adder_share_arb (imported), testbench.
package adder_share_pkg;

  // Default operand width in bits.
  localparam int W_DEF = 3;

  // Saturation ceiling of the accepted-request counter.
  localparam logic [7:0] CNT_MAX = 8'd255;

  // IDLE: no result held. RESP: a result is held and rsp_valid is high.
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage : adder_share_pkg

// File: rtl/adder_core.sv
// Purpose : purely combinational W-bit adder, {cout,sum} = a + b + cin.
// Latency : zero cycles (no state).
// Ports   : a, b (W bits), cin -> sum (W bits), cout.
module adder_core #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Widen every operand to W+1 bits so the carry-out is the top bit.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule : adder_core

// File: rtl/adder_share_arb.sv
// Purpose : shares one adder between two valid/ready requesters; the result is registered.
// Latency : a result is visible the cycle after acceptance; one result per cycle when rsp_ready stays high.
// Backpressure: while a held result is not accepted (rsp_ready=0), req_ready stays 0 and the result holds.
// Ports   : clk, rst_n; req_valid[1:0]/req_ready[1:0] with a0,b0,cin0 / a1,b1,cin1;
//           rsp_valid/rsp_ready with rsp_sum, rsp_cout, rsp_id; ops_cnt (saturating accept count).
module adder_share_arb
  import adder_share_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         cin0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         cin1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_id,
  output logic [7:0]   ops_cnt
);

  state_t       state;
  state_t       state_nxt;
  logic         last_grant;
  logic         gnt_vld;
  logic         gnt_id;
  logic         can_accept;
  logic         accept;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic         add_cout;

  // Grant: a lone requester wins; on conflict the one not granted last time wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    case (req_valid)
      2'b01:   begin gnt_vld = 1'b1; gnt_id = 1'b0;        end
      2'b10:   begin gnt_vld = 1'b1; gnt_id = 1'b1;        end
      2'b11:   begin gnt_vld = 1'b1; gnt_id = ~last_grant; end
      default: begin gnt_vld = 1'b0; gnt_id = 1'b0;        end
    endcase
  end

  // A new result may be taken when nothing is held or the held one leaves this cycle.
  assign can_accept = (state == IDLE) | ((state == RESP) & rsp_ready);
  assign accept     = can_accept & gnt_vld;

  // rst_n gates only the output so that reset never enters a flop data path.
  assign req_ready  = {2{rst_n & accept}} & {gnt_id, ~gnt_id};
  assign rsp_valid  = (state == RESP);

  // Only the granted requester's operands reach the adder.
  assign add_a   = gnt_id ? a1   : a0;
  assign add_b   = gnt_id ? b1   : b0;
  assign add_cin = gnt_id ? cin1 : cin0;

  adder_core #(
    .W (W)
  ) u_adder_core (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RESP;
      end
      RESP: begin
        if (accept)         state_nxt = RESP;
        else if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Result registers load only on accept, so they hold under backpressure.
  // last_grant resets to 1 so requester 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_sum    <= add_sum;
      rsp_cout   <= add_cout;
      rsp_id     <= gnt_id;
      last_grant <= gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_cnt <= 8'd0;
    end else if (accept && (ops_cnt != CNT_MAX)) begin
      ops_cnt <= ops_cnt + 8'd1;
    end
  end

endmodule : adder_share_arb

// File: tb/tb_adder_share_arb.sv
// Purpose : self-checking bench for adder_share_arb; directed steps plus random traffic
//           checked against a transaction-level model (result slot, last winner, count).
// Ports   : drives every DUT input, samples outputs just after the falling edge.
module tb_adder_share_arb;

  localparam int W   = 3;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] a0, b0, a1, b1;
  logic         cin0, cin1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_id;
  logic [7:0]   ops_cnt;

  always #5 clk = ~clk;

  adder_share_arb #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a0        (a0),
    .b0        (b0),
    .cin0      (cin0),
    .a1        (a1),
    .b1        (b1),
    .cin1      (cin1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .ops_cnt   (ops_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the held result (if any), who won last, accepted count.
  bit m_vld;
  int m_sum, m_cout, m_id, m_last, m_cnt;
  int last_acc;   // requester accepted on the most recent cycle, -1 if none

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_sum = 0; m_cout = 0; m_id = 0; m_last = 1; m_cnt = 0; last_acc = -1;
  endtask

  // One clock with the inputs already driven (called just after a falling edge).
  task automatic cycle();
    int  win;
    int  total;
    bit  room;
    logic [1:0] exp_rdy;
    #1;
    room = !m_vld || rsp_ready;
    if (req_valid == 2'b01)      win = 0;
    else if (req_valid == 2'b10) win = 1;
    else if (req_valid == 2'b11) win = 1 - m_last;
    else                         win = -1;
    exp_rdy = (room && win >= 0) ? 2'(1 << win) : 2'b00;
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    @(posedge clk);
    if (exp_rdy != 2'b00) begin
      if (win == 0) total = int'(a0) + int'(b0) + int'(cin0);
      else          total = int'(a1) + int'(b1) + int'(cin1);
      m_sum  = total % MOD;
      m_cout = (total >= MOD) ? 1 : 0;
      m_id   = win;
      m_last = win;
      m_vld  = 1;
      if (m_cnt < 255) m_cnt++;
      last_acc = win;
    end else begin
      if (m_vld && rsp_ready) m_vld = 0;
      last_acc = -1;
    end
    @(negedge clk);
    chk("rsp_valid", {31'd0, rsp_valid}, m_vld);
    if (m_vld) begin
      chk("rsp_sum",  {29'd0, rsp_sum},  m_sum);
      chk("rsp_cout", {31'd0, rsp_cout}, m_cout);
      chk("rsp_id",   {31'd0, rsp_id},   m_id);
    end
    chk("ops_cnt", {24'd0, ops_cnt}, m_cnt);
  endtask

  // Random traffic that obeys the hold-until-ready rule.
  task automatic drive_rand(input int pct_valid);
    for (int i = 0; i < 2; i++) begin
      if (!(req_valid[i] && last_acc != i)) begin
        req_valid[i] = ($urandom_range(99) < pct_valid);
        if (i == 0) begin
          a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
        end else begin
          a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
        end
      end
    end
    rsp_ready = ($urandom_range(99) < 70);
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic         held_cout, held_id;

    // Reset state.
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    a0 = '0; b0 = '0; cin0 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    model_reset();
    #12;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_sum",   {29'd0, rsp_sum},   0);
    chk("rst_rsp_cout",  {31'd0, rsp_cout},  0);
    chk("rst_rsp_id",    {31'd0, rsp_id},    0);
    chk("rst_ops_cnt",   {24'd0, ops_cnt},   0);
    req_valid = 2'b11; #1;
    chk("rst_req_ready", {30'd0, req_ready}, 0);
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;

    // Single request: 3+2+1 = 6.
    req_valid = 2'b01; a0 = 3'd3; b0 = 3'd2; cin0 = 1'b1; rsp_ready = 1'b1;
    cycle();
    chk("single_sum",  {29'd0, rsp_sum},  6);
    chk("single_cout", {31'd0, rsp_cout}, 0);
    chk("single_id",   {31'd0, rsp_id},   0);
    chk("single_cnt",  {24'd0, ops_cnt},  1);

    // Overflow: 7+7+1 = 15 -> sum 7, cout 1.
    req_valid = 2'b10; a1 = 3'd7; b1 = 3'd7; cin1 = 1'b1;
    cycle();
    chk("ovf_sum",  {29'd0, rsp_sum},  7);
    chk("ovf_cout", {31'd0, rsp_cout}, 1);
    chk("ovf_id",   {31'd0, rsp_id},   1);
    req_valid = 2'b00;
    cycle();

    // Backpressure: result held 3 cycles while req1 waits, then req1 taken at once.
    req_valid = 2'b01; a0 = 3'd1; b0 = 3'd1; cin0 = 1'b0; rsp_ready = 1'b1;
    cycle();
    held_sum = rsp_sum; held_cout = rsp_cout; held_id = rsp_id;
    req_valid = 2'b10; a1 = 3'd4; b1 = 3'd5; cin1 = 1'b0; rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_sum_hold",  {29'd0, rsp_sum},  {29'd0, held_sum});
      chk("bp_cout_hold", {31'd0, rsp_cout}, {31'd0, held_cout});
      chk("bp_id_hold",   {31'd0, rsp_id},   {31'd0, held_id});
    end
    rsp_ready = 1'b1; #1;
    chk("bp_release_rdy", {30'd0, req_ready}, 2);
    cycle();
    chk("bp_release_sum", {29'd0, rsp_sum}, 1);
    chk("bp_release_id",  {31'd0, rsp_id},  1);

    // Reset mid-operation while a result is held.
    req_valid = 2'b11; rsp_ready = 1'b0;
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 0);
    chk("mid_rst_cnt",   {24'd0, ops_cnt},   0);
    chk("mid_rst_rdy",   {30'd0, req_ready}, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;

    // Conflict after reset: grants alternate 0,1,0,1.
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b11;
      a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom);
      cycle();
      chk("conflict_grant", last_acc, k % 2);
      chk("conflict_id",    {31'd0, rsp_id}, k % 2);
    end
    req_valid = 2'b00;
    cycle();

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      drive_rand(60);
      cycle();
    end

    // Saturation: 260 more accepts on requester 0.
    req_valid = 2'b00; rsp_ready = 1'b1;
    cycle();
    for (int k = 0; k < 260; k++) begin
      req_valid = 2'b01; a0 = W'($urandom); b0 = W'($urandom); cin0 = 1'($urandom);
      cycle();
    end
    chk("sat_cnt", {24'd0, ops_cnt}, 255);
    for (int k = 0; k < 5; k++) begin
      drive_rand(90);
      cycle();
    end
    chk("sat_cnt_hold", {24'd0, ops_cnt}, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_adder_share_arb
